// File: rtl/spi_cmd_decoder.sv
// SPI command decoder: collects a fixed-length command frame, executes it against a
// small register file and streams back a fixed-length response frame.
module spi_cmd_decoder #(
  parameter int RX_BYTES = 4,
  parameter int TX_BYTES = 4,
  parameter int NUM_REGS = 8
) (
  input  logic        sysClk,
  input  logic        reset,
  input  logic [7:0]  rxByte,
  input  logic        rxValid,
  input  logic        csActive,
  input  logic        txReady,
  output logic [7:0]  txByte,
  output logic        txValid,
  output logic        cmdDone,
  output logic [15:0] ctrlReg,
  output logic [7:0]  errCount
);

  // Buffers hold at least the 4 decoded bytes even for shorter frame parameters.
  localparam int RXB = (RX_BYTES < 4) ? 4 : RX_BYTES;
  localparam int TXB = (TX_BYTES < 4) ? 4 : TX_BYTES;
  localparam int RIW = (RX_BYTES > 1) ? $clog2(RX_BYTES) : 1;
  localparam int TIW = (TX_BYTES > 1) ? $clog2(TX_BYTES) : 1;
  localparam int AW  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  typedef enum logic [1:0] {IDLE, COLLECT, EXEC, RESPOND} state_t;

  state_t         state, nstate;
  logic [RIW-1:0] rxIdx;
  logic [TIW-1:0] txIdx;
  logic [7:0]     rxBuf [RXB];
  logic [7:0]     resp  [TXB];
  logic [15:0]    regs  [NUM_REGS];

  logic [7:0]     opc, addr;
  logic [15:0]    wdata, rdata;
  logic [AW-1:0]  aidx;
  logic           addr_ok, is_err, do_write, err_inc;
  logic           rx_last, tx_last;
  logic [7:0]     r4 [4];

  assign opc     = rxBuf[0];
  assign addr    = rxBuf[1];
  assign wdata   = {rxBuf[2], rxBuf[3]};
  assign aidx    = addr[AW-1:0];
  assign addr_ok = int'(addr) < NUM_REGS;
  assign rdata   = addr_ok ? regs[aidx] : 16'h0000;
  assign ctrlReg = regs[0];

  assign rx_last = rxValid && (rxIdx == RIW'(RX_BYTES - 1));
  assign tx_last = txReady && (txIdx == TIW'(TX_BYTES - 1));

  always_ff @(posedge sysClk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= nstate;
  end

  always_comb begin
    nstate  = state;
    cmdDone = 1'b0;
    txValid = 1'b0;
    txByte  = 8'h00;
    case (state)
      IDLE:    if (csActive) nstate = COLLECT;
      // A completing byte wins over a simultaneous chip-select drop.
      COLLECT: if (rx_last) nstate = EXEC;
               else if (!csActive) nstate = IDLE;
      EXEC: begin
        cmdDone = 1'b1;
        nstate  = RESPOND;
      end
      RESPOND: begin
        txValid = 1'b1;
        txByte  = resp[txIdx];
        if (tx_last) nstate = IDLE;
      end
      default: nstate = IDLE;
    endcase
  end

  // Opcode decode and response image, evaluated from the collected frame.
  always_comb begin
    is_err   = 1'b0;
    do_write = 1'b0;
    r4       = '{8'hEE, opc, 8'h00, 8'h00};
    case (opc)
      8'h00: r4 = '{8'hA5, 8'h00, errCount, 8'h5A};
      8'h01: if (addr_ok) begin
               do_write = 1'b1;
               r4 = '{8'hA5, addr, wdata[15:8], wdata[7:0]};
             end else is_err = 1'b1;
      8'h02: if (addr_ok) r4 = '{8'hA5, addr, rdata[15:8], rdata[7:0]};
             else is_err = 1'b1;
      8'h03: r4 = '{rxBuf[0], rxBuf[1], rxBuf[2], rxBuf[3]};
      default: is_err = 1'b1;
    endcase
    if (is_err) r4 = '{8'hEE, opc, 8'h00, 8'h00};
  end

  assign err_inc = ((state == COLLECT) && !rx_last && !csActive) ||
                   ((state == EXEC) && is_err);

  always_ff @(posedge sysClk or posedge reset) begin
    if (reset) begin
      rxIdx    <= '0;
      txIdx    <= '0;
      errCount <= 8'h00;
      for (int i = 0; i < RXB; i++) rxBuf[i] <= 8'h00;
      for (int i = 0; i < TXB; i++) resp[i] <= 8'h00;
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= 16'h0000;
    end else begin
      if (err_inc && errCount != 8'hFF) errCount <= errCount + 8'd1;
      case (state)
        IDLE: begin
          rxIdx <= '0;
          txIdx <= '0;
        end
        COLLECT: if (rxValid) begin
          rxBuf[rxIdx] <= rxByte;
          if (!rx_last) rxIdx <= rxIdx + 1'b1;
        end
        EXEC: begin
          for (int i = 0; i < TXB; i++) resp[i] <= 8'h00;
          for (int i = 0; i < 4; i++) resp[i] <= r4[i];
          if (do_write) regs[aidx] <= wdata;
        end
        RESPOND: if (txReady && !tx_last) txIdx <= txIdx + 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_cmd_decoder.sv
// Bench for spi_cmd_decoder: table of command frames with expected responses fed
// through a byte scoreboard, plus hand sequences for abort, late chip-select and reset.
module tb_spi_cmd_decoder;

  logic        sysClk = 1'b0;
  logic        reset;
  logic [7:0]  rxByte;
  logic        rxValid, csActive, txReady;
  logic [7:0]  txByte;
  logic        txValid, cmdDone;
  logic [15:0] ctrlReg;
  logic [7:0]  errCount;

  spi_cmd_decoder #(.RX_BYTES(4), .TX_BYTES(4), .NUM_REGS(8)) dut (
    .sysClk(sysClk), .reset(reset), .rxByte(rxByte), .rxValid(rxValid),
    .csActive(csActive), .txReady(txReady), .txByte(txByte), .txValid(txValid),
    .cmdDone(cmdDone), .ctrlReg(ctrlReg), .errCount(errCount)
  );

  always #5 sysClk = ~sysClk;

  typedef struct {
    logic [3:0][7:0] cmd;
    logic [3:0][7:0] rsp;
    logic [15:0]     ctrl;
    logic [7:0]      err;
  } vec_t;

  int         total = 0;
  int         bad = 0;
  int         done_cnt = 0;
  logic [7:0] sb [$];
  vec_t       tbl [12];

  always @(negedge sysClk) if (cmdDone) done_cnt++;

  function automatic vec_t row(input logic [7:0] c0, c1, c2, c3, r0, r1, r2, r3,
                               input logic [15:0] ctrl, input logic [7:0] err);
    vec_t v;
    v.cmd  = {c3, c2, c1, c0};
    v.rsp  = {r3, r2, r1, r0};
    v.ctrl = ctrl;
    v.err  = err;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge sysClk);
    #1;
  endtask

  // Drive a full frame; the final byte may coincide with chip-select dropping.
  task automatic send(input vec_t v, input bit late_cs);
    csActive = 1'b1;
    tick;
    for (int i = 0; i < 4; i++) begin
      rxValid = 1'b1;
      rxByte  = v.cmd[i];
      if (late_cs && i == 3) csActive = 1'b0;
      tick;
    end
    rxValid = 1'b0;
    rxByte  = 8'h00;
    chk("cmdDone_exec", cmdDone, 1);
    chk("txValid_exec", txValid, 0);
    chk("txByte_exec", txByte, 8'h00);
    for (int i = 0; i < 4; i++) sb.push_back(v.rsp[i]);
    tick;
    chk("txValid_resp", txValid, 1);
  endtask

  task automatic pop_cmp;
    logic [7:0] e;
    if (sb.size() == 0) begin
      chk("scoreboard_empty", 1, 0);
    end else begin
      e = sb.pop_front();
      chk("txByte", txByte, e);
    end
  endtask

  // Consume n response bytes; noisy mode toggles csActive and pulses rxValid meanwhile.
  task automatic drain(input int n, input bit noisy);
    for (int i = 0; i < n; i++) begin
      chk("txValid_hold", txValid, 1);
      pop_cmp();
      txReady = 1'b1;
      if (noisy) begin
        csActive = ~csActive;
        rxValid  = 1'b1;
        rxByte   = 8'h99;
      end
      tick;
      txReady = 1'b0;
      rxValid = 1'b0;
      if (noisy && i != n - 1) tick;
    end
  endtask

  task automatic finish_frame;
    chk("txValid_after", txValid, 0);
    chk("txByte_after", txByte, 8'h00);
    csActive = 1'b0;
    tick;
  endtask

  task automatic run(input vec_t v);
    int d0;
    d0 = done_cnt;
    send(v, 1'b0);
    drain(4, 1'b0);
    finish_frame();
    chk("cmdDone_count", done_cnt - d0, 1);
    chk("ctrlReg", ctrlReg, v.ctrl);
    chk("errCount", errCount, v.err);
  endtask

  task automatic abort2;
    csActive = 1'b1;
    tick;
    for (int i = 0; i < 2; i++) begin
      rxValid = 1'b1;
      rxByte  = 8'h01 + 8'(i);
      tick;
    end
    rxValid  = 1'b0;
    csActive = 1'b0;
    tick;
  endtask

  initial begin
    int d0;
    reset    = 1'b1;
    rxByte   = 8'h00;
    rxValid  = 1'b0;
    csActive = 1'b0;
    txReady  = 1'b0;

    tbl[0]  = row(8'h01, 8'h00, 8'h12, 8'h34, 8'hA5, 8'h00, 8'h12, 8'h34, 16'h1234, 8'd0);
    tbl[1]  = row(8'h01, 8'h03, 8'hBE, 8'hEF, 8'hA5, 8'h03, 8'hBE, 8'hEF, 16'h1234, 8'd0);
    tbl[2]  = row(8'h02, 8'h03, 8'h00, 8'h00, 8'hA5, 8'h03, 8'hBE, 8'hEF, 16'h1234, 8'd0);
    tbl[3]  = row(8'h03, 8'h11, 8'h22, 8'h33, 8'h03, 8'h11, 8'h22, 8'h33, 16'h1234, 8'd0);
    tbl[4]  = row(8'h07, 8'h01, 8'h02, 8'h03, 8'hEE, 8'h07, 8'h00, 8'h00, 16'h1234, 8'd1);
    tbl[5]  = row(8'h02, 8'h08, 8'h00, 8'h00, 8'hEE, 8'h02, 8'h00, 8'h00, 16'h1234, 8'd2);
    tbl[6]  = row(8'h00, 8'h00, 8'h00, 8'h00, 8'hA5, 8'h00, 8'h02, 8'h5A, 16'h1234, 8'd2);
    tbl[7]  = row(8'h01, 8'h07, 8'hCA, 8'hFE, 8'hA5, 8'h07, 8'hCA, 8'hFE, 16'h1234, 8'd2);
    tbl[8]  = row(8'h02, 8'h07, 8'h55, 8'h55, 8'hA5, 8'h07, 8'hCA, 8'hFE, 16'h1234, 8'd2);
    tbl[9]  = row(8'h01, 8'hFF, 8'h11, 8'h11, 8'hEE, 8'h01, 8'h00, 8'h00, 16'h1234, 8'd3);
    tbl[10] = row(8'h01, 8'h00, 8'hAB, 8'hCD, 8'hA5, 8'h00, 8'hAB, 8'hCD, 16'hABCD, 8'd3);
    tbl[11] = row(8'h00, 8'h12, 8'h34, 8'h56, 8'hA5, 8'h00, 8'h03, 8'h5A, 16'hABCD, 8'd3);

    tick;
    tick;
    chk("rst_txByte", txByte, 8'h00);
    chk("rst_txValid", txValid, 0);
    chk("rst_cmdDone", cmdDone, 0);
    chk("rst_ctrlReg", ctrlReg, 16'h0000);
    chk("rst_errCount", errCount, 8'h00);
    reset = 1'b0;
    tick;

    for (int i = 0; i < 12; i++) run(tbl[i]);

    // Short frame: chip-select drops after two bytes.
    d0 = done_cnt;
    abort2();
    chk("abort_no_cmdDone", done_cnt - d0, 0);
    chk("abort_errCount", errCount, 8'd4);
    chk("abort_ctrlReg", ctrlReg, 16'hABCD);
    run(row(8'h01, 8'h00, 8'h12, 8'h34, 8'hA5, 8'h00, 8'h12, 8'h34, 16'h1234, 8'd4));

    // Final byte arrives with chip-select already low; response survives cs/rx noise.
    d0 = done_cnt;
    send(row(8'h03, 8'hAA, 8'hBB, 8'hCC, 8'h03, 8'hAA, 8'hBB, 8'hCC, 16'h1234, 8'd4), 1'b1);
    drain(4, 1'b1);
    finish_frame();
    chk("late_cs_cmdDone", done_cnt - d0, 1);
    chk("late_cs_errCount", errCount, 8'd4);
    chk("late_cs_ctrlReg", ctrlReg, 16'h1234);

    for (int i = 0; i < 300; i++) abort2();
    chk("err_saturate", errCount, 8'hFF);

    // Reset in the middle of a response.
    send(row(8'h01, 8'h00, 8'h55, 8'h66, 8'hA5, 8'h00, 8'h55, 8'h66, 16'h5566, 8'hFF), 1'b0);
    drain(2, 1'b0);
    chk("pre_rst_ctrlReg", ctrlReg, 16'h5566);
    reset = 1'b1;
    #1;
    chk("midrst_txValid", txValid, 0);
    chk("midrst_txByte", txByte, 8'h00);
    chk("midrst_ctrlReg", ctrlReg, 16'h0000);
    chk("midrst_errCount", errCount, 8'h00);
    sb.delete();
    csActive = 1'b0;
    tick;
    reset = 1'b0;
    tick;
    run(row(8'h01, 8'h00, 8'h12, 8'h34, 8'hA5, 8'h00, 8'h12, 8'h34, 16'h1234, 8'd0));
    chk("sb_empty_end", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/spi_cmd_decoder.md
SPI_CMD_DECODER -- requirements
Module: spi_cmd_decoder

Interface
REQ-001 The block SHALL have parameter RX_BYTES, default 4, meaning command frame length in bytes.
REQ-002 The block SHALL have parameter TX_BYTES, default 4, meaning response frame length in bytes.
REQ-003 The block SHALL have parameter NUM_REGS, default 8, meaning number of 16-bit registers.
REQ-004 Port sysClk, input, 1, single system clock; all logic on its rising edge.
REQ-005 Port reset, input, 1, asynchronous active-high reset.
REQ-006 Port rxByte, input, 8, byte received from the SPI slave.
REQ-007 Port rxValid, input, 1, one-cycle pulse qualifying rxByte.
REQ-008 Port csActive, input, 1, high while the SPI frame is selected; synchronous to sysClk.
REQ-009 Port txReady, input, 1, one-cycle pulse: slave has latched txByte and wants the next byte.
REQ-010 Port txByte, output, 8, next response byte for the slave.
REQ-011 Port txValid, output, 1, high while txByte holds a valid response byte.
REQ-012 Port cmdDone, output, 1, one-cycle pulse when a command executes.
REQ-013 Port ctrlReg, output, 16, live value of register 0.
REQ-014 Port errCount, output, 8, saturating count of errored or aborted commands.

Function
REQ-015 Frame format SHALL be byte0 opcode, byte1 address, byte2 data[15:8], byte3 data[7:0].
REQ-016 Opcodes SHALL be: 0x00 NOP, 0x01 WRITE, 0x02 READ, 0x03 ECHO; all others are illegal.
REQ-017 States SHALL be IDLE, COLLECT, EXEC, RESPOND.
REQ-018 IDLE SHALL clear rxIdx and txIdx and move to COLLECT when csActive is high.
REQ-019 COLLECT SHALL store rxByte at rxIdx on rxValid and increment rxIdx.
REQ-020 When the RX_BYTES-th byte is stored, COLLECT SHALL move to EXEC on the next cycle.
REQ-021 If csActive is low in COLLECT with fewer than RX_BYTES stored, the block SHALL discard the frame, increment errCount, and return to IDLE.
REQ-022 rxValid coinciding with csActive low SHALL be accepted first; a completing byte goes to EXEC with no abort.
REQ-023 EXEC SHALL last exactly one cycle, pulse cmdDone, build the response buffer, and move to RESPOND.
REQ-024 WRITE SHALL load reg[addr] with data; the response is A5, addr, data.
REQ-025 READ SHALL leave registers unchanged; the response is A5, addr, reg[addr].
REQ-026 ECHO SHALL respond with the 4 received bytes unchanged.
REQ-027 NOP SHALL respond with A5, 00, errCount, 5A.
REQ-028 An illegal opcode, or WRITE/READ with addr >= NUM_REGS, SHALL perform no write, respond EE, opcode, 00, 00, and increment errCount.
REQ-029 Latency: last rxValid in cycle N gives cmdDone in N+1 and txValid with txByte=resp[0] in N+2.
REQ-030 RESPOND SHALL drive txByte=resp[txIdx] with txValid=1, and increment txIdx on txReady.
REQ-031 After the TX_BYTES-th txReady, RESPOND SHALL return to IDLE with txValid=0.
REQ-032 RESPOND SHALL persist across csActive toggles and ignore rxValid; the host clocks dummy bytes.
REQ-033 Outside RESPOND, txByte SHALL be 0x00, txValid 0, and txReady ignored.
REQ-034 errCount SHALL saturate at 0xFF and never wrap.
REQ-035 rxIdx and txIdx SHALL be wide enough for RX_BYTES/TX_BYTES and SHALL never index out of range.

Reset
REQ-036 reset SHALL immediately force IDLE and clear rxIdx, txIdx, the response buffer, and all registers.
REQ-037 On reset, txByte SHALL be 0x00, txValid 0, cmdDone 0, ctrlReg 0x0000, and errCount 0x00.
REQ-038 Reset mid-COLLECT or mid-RESPOND SHALL drop the partial frame and response; operation resumes at IDLE on deassertion.

Verification
REQ-039 WRITE 01,00,12,34 then 4 txReady -> cmdDone once; ctrlReg=0x1234; tx sequence A5,00,12,34.
REQ-040 WRITE 01,03,BE,EF then READ 02,03,00,00 -> read response A5,03,BE,EF.
REQ-041 ECHO 03,11,22,33 -> tx 03,11,22,33; no register change.
REQ-042 Opcode 07 or READ with addr 08 -> tx EE,opcode,00,00; errCount +1.
REQ-043 csActive low after 2 bytes -> no cmdDone, errCount +1, next full frame executes normally; 300 aborts -> errCount=0xFF.
REQ-044 Reset asserted after 2nd txReady -> txValid=0 at once; ctrlReg=0; next WRITE behaves as in REQ-039.
